// File: rtl/regbank_pkg.sv
// Shared types and defaults for the multi-read-port register bank.
package regbank_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_RD_DEF = 2;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/regbank_rdport.sv
// One read port of the register bank: ready gating, hardwired-zero entry and write bypass.
module regbank_rdport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              ready,
    input  logic [ADDR_W-1:0] ra,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] dr
);

    // Priority matters: the zero entry must win over bypass so a dropped write to 0 never leaks.
    always_comb begin
        dr = rdata;
        if (!ready) begin
            dr = '0;
        end else if ((ZERO_REG != 0) && (ra == '0)) begin
            dr = '0;
        end else if ((BYPASS != 0) && wr_en && (wa == ra)) begin
            dr = din;
        end
    end

endmodule

// File: rtl/regbank_mp.sv
// Parametrised register bank with NUM_RD read ports, write bypass and a post-reset clear sequencer.
//   state | meaning
//   CLEAR | zeroing entry clr_idx each cycle; writes are dropped, reads return 0
//   RUN   | bank ready; writes land on the rising edge, reads are combinational
module regbank_mp
    import regbank_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        din,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] dr,
    output logic                     ready,
    output logic                     drop
);

    localparam int DEPTH = depth_of(ADDR_W);

    state_t            state, state_d;
    logic [ADDR_W-1:0] clr_idx, clr_idx_d;
    logic              zero_hit;
    logic              wr_ok;
    logic              drop_d;

    logic [DATA_W-1:0] mem [DEPTH];

    assign zero_hit = (ZERO_REG != 0) && (wa == '0);
    assign wr_ok    = wr_en && (state == RUN) && !zero_hit;
    assign drop_d   = wr_en && ((state == CLEAR) || zero_hit);
    assign ready    = (state == RUN);

    // clr_idx parks at DEPTH-1 once the clear finishes rather than wrapping.
    always_comb begin
        state_d   = state;
        clr_idx_d = clr_idx;
        if (state == CLEAR) begin
            if (clr_idx == '1) begin
                state_d = RUN;
            end else begin
                clr_idx_d = clr_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_idx <= '0;
            drop    <= 1'b0;
        end else begin
            state   <= state_d;
            clr_idx <= clr_idx_d;
            drop    <= drop_d;
        end
    end

    // The array has no reset; its contents are defined only by the clear sequence.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_idx] <= '0;
        end else if (wr_ok) begin
            mem[wa] <= din;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] ra_p;
        assign ra_p = ra[p*ADDR_W +: ADDR_W];

        regbank_rdport #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG),
            .BYPASS  (BYPASS)
        ) u_rdport (
            .ready(ready),
            .ra   (ra_p),
            .wr_en(wr_en),
            .wa   (wa),
            .din  (din),
            .rdata(mem[ra_p]),
            .dr   (dr[p*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_regbank_mp.sv
// Scoreboard bench for regbank_mp: a bypassing instance and a non-bypassing instance share stimulus.
module tb_regbank_mp;

    localparam int KIND_DR    = 0;
    localparam int KIND_DR_NB = 1;
    localparam int KIND_RDY   = 2;
    localparam int KIND_RDYNB = 3;
    localparam int KIND_DROP  = 4;

    typedef struct {
        int          kind;
        int          port;
        logic [31:0] val;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wa;
    logic [31:0] din;
    logic [9:0]  ra;
    logic [63:0] dr_main, dr_nb;
    logic        ready_main, ready_nb;
    logic        drop_main, drop_nb;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks   = 0;
    int    failures = 0;

    regbank_mp u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .wr_en(wr_en),
        .wa   (wa),
        .din  (din),
        .ra   (ra),
        .dr   (dr_main),
        .ready(ready_main),
        .drop (drop_main)
    );

    regbank_mp #(.BYPASS(0)) u_nobyp (
        .clk  (clk),
        .rst_n(rst_n),
        .wr_en(wr_en),
        .wa   (wa),
        .din  (din),
        .ra   (ra),
        .dr   (dr_nb),
        .ready(ready_nb),
        .drop (drop_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input int kind, input int port, input logic [31:0] val, input string name);
        exp_t e;
        e.kind = kind;
        e.port = port;
        e.val  = val;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    task automatic set_ra(input logic [4:0] p1, input logic [4:0] p0);
        ra = {p1, p0};
    endtask

    // Monitor: outputs are settled by the falling edge; drain every pending expectation there.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t        e;
            string       nm;
            logic [31:0] got;
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            got = 32'h0;
            case (e.kind)
                KIND_DR:    got = dr_main[e.port*32 +: 32];
                KIND_DR_NB: got = dr_nb[e.port*32 +: 32];
                KIND_RDY:   got = {31'h0, ready_main};
                KIND_RDYNB: got = {31'h0, ready_nb};
                KIND_DROP:  got = {31'h0, drop_main};
                default:    got = 32'hxxxx_xxxx;
            endcase
            checks++;
            if (got !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, e.val, $time);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0;
        wa    = '0;
        din   = '0;
        ra    = '0;
        repeat (3) @(posedge clk);
        #1;
        expect_v(KIND_RDY, 0, 32'h0, "reset_ready");
        expect_v(KIND_DROP, 0, 32'h0, "reset_drop");
        expect_v(KIND_DR, 0, 32'h0, "reset_dr0");
        rst_n = 1'b1;

        for (int k = 1; k <= 32; k++) begin
            tick();
            expect_v(KIND_RDY, 0, (k == 32) ? 32'h1 : 32'h0, "clear_ready");
            if (k == 31 || k == 32)
                expect_v(KIND_RDYNB, 0, (k == 32) ? 32'h1 : 32'h0, "clear_ready_nb");
        end
        checks++;
        if (ready_main !== 1'b1) begin
            failures++;
            $display("FAIL direct_ready_after_clear: got %b expected 1 (t=%0t)", ready_main, $time);
        end

        for (int a = 0; a < 32; a++) begin
            set_ra(5'(31 - a), 5'(a));
            #1;
            expect_v(KIND_DR, 0, 32'h0, "cleared_p0");
            expect_v(KIND_DR, 1, 32'h0, "cleared_p1");
            tick();
        end

        wr_en = 1'b1; wa = 5'd5;  din = 32'hDEADBEEF;
        tick();
        wa = 5'd31; din = 32'h12345678;
        tick();
        wr_en = 1'b0;
        set_ra(5'd5, 5'd31);
        expect_v(KIND_DR, 0, 32'h12345678, "rd_p0_31");
        expect_v(KIND_DR, 1, 32'hDEADBEEF, "rd_p1_5");
        expect_v(KIND_DROP, 0, 32'h0, "normal_write_no_drop");
        #1;
        checks++;
        if (dr_main !== {32'hDEADBEEF, 32'h12345678}) begin
            failures++;
            $display("FAIL direct_rd_pair: got %h (t=%0t)", dr_main, $time);
        end
        tick();
        set_ra(5'd5, 5'd5);
        expect_v(KIND_DR, 0, 32'hDEADBEEF, "same_addr_p0");
        expect_v(KIND_DR, 1, 32'hDEADBEEF, "same_addr_p1");
        tick();

        wr_en = 1'b1; wa = 5'd0; din = 32'hFFFFFFFF;
        set_ra(5'd0, 5'd0);
        expect_v(KIND_DR, 0, 32'h0, "zero_bypass_p0");
        expect_v(KIND_DROP, 0, 32'h0, "zero_drop_before");
        tick();
        wr_en = 1'b0;
        expect_v(KIND_DROP, 0, 32'h1, "zero_drop_pulse");
        expect_v(KIND_DR, 1, 32'h0, "zero_read_p1");
        tick();
        expect_v(KIND_DROP, 0, 32'h0, "zero_drop_end");
        wr_en = 1'b1;
        tick();
        tick();
        wr_en = 1'b0;
        expect_v(KIND_DROP, 0, 32'h1, "drop_back_to_back");
        tick();
        expect_v(KIND_DROP, 0, 32'h0, "drop_b2b_end");

        wr_en = 1'b1; wa = 5'd7; din = 32'h11111111;
        tick();
        din = 32'hA5A5A5A5;
        set_ra(5'd7, 5'd7);
        expect_v(KIND_DR, 0, 32'hA5A5A5A5, "bypass_before_edge");
        expect_v(KIND_DR_NB, 1, 32'h11111111, "nobypass_before_edge");
        tick();
        wr_en = 1'b0;
        expect_v(KIND_DR, 1, 32'hA5A5A5A5, "bypass_after_edge");
        expect_v(KIND_DR_NB, 0, 32'hA5A5A5A5, "nobypass_after_edge");
        tick();

        wr_en = 1'b1; wa = 5'd9; din = 32'h00000055;
        tick();
        wa = 5'd3; din = 32'h00000033;
        tick();
        wr_en = 1'b0;
        set_ra(5'd3, 5'd9);
        expect_v(KIND_DR, 0, 32'h00000055, "pre_reset_e9");
        expect_v(KIND_DR, 1, 32'h00000033, "pre_reset_e3");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        set_ra(5'd9, 5'd9);
        expect_v(KIND_RDY, 0, 32'h0, "async_ready_drop");
        expect_v(KIND_RDYNB, 0, 32'h0, "async_ready_drop_nb");
        expect_v(KIND_DR, 0, 32'h0, "not_ready_dr_zero");
        #1;
        checks++;
        if (ready_main !== 1'b0) begin
            failures++;
            $display("FAIL direct_async_ready: got %b expected 0 (t=%0t)", ready_main, $time);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            if (k == 10) begin
                wr_en = 1'b1; wa = 5'd3; din = 32'hCAFEF00D;
            end
            tick();
            wr_en = 1'b0;
            if (k == 10) expect_v(KIND_DROP, 0, 32'h1, "clear_write_drop");
            if (k == 11) expect_v(KIND_DROP, 0, 32'h0, "clear_write_drop_end");
            if (k == 31) expect_v(KIND_RDY, 0, 32'h0, "reclear_ready_31");
            if (k == 32) expect_v(KIND_RDY, 0, 32'h1, "reclear_ready_32");
        end
        set_ra(5'd3, 5'd9);
        expect_v(KIND_DR, 0, 32'h0, "reclear_e9");
        expect_v(KIND_DR, 1, 32'h0, "reclear_e3");
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
